// File: rtl/imem_pkg.sv
// Shared types and ROM image for the LEGv8 instruction-memory responder.
package imem_pkg;

    // Responder FSM states: idle, counting down latency, presenting a response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_t;

    // Word returned for any fetch that cannot be served from the ROM.
    localparam logic [31:0] IMEM_NOP = 32'h8B1F03FF;

    // Number of explicitly programmed words; everything above reads as NOP.
    localparam int IMEM_INIT_LEN = 4;

    // Programmed ROM contents, indexed by word address.
    localparam logic [31:0] IMEM_INIT [IMEM_INIT_LEN] = '{
        32'hF8400020,
        32'h8B020023,
        32'hCB050086,
        32'hB4000060
    };

    // Look up one ROM word; indices past the programmed image read as NOP.
    function automatic logic [31:0] imem_image_word(input int unsigned idx);
        logic [1:0] short_idx;
        short_idx = idx[1:0];
        if (idx < IMEM_INIT_LEN) begin
            return IMEM_INIT[short_idx];
        end
        return IMEM_NOP;
    endfunction

endpackage

// File: rtl/imem_rom.sv
// Combinational instruction ROM: word lookup plus out-of-range and alignment decode.
module imem_rom #(
    parameter int N     = 64,
    parameter int WORDS = 64
) (
    input  logic [N-1:0] addr,
    output logic [31:0]  data,
    output logic         misalign
);
    import imem_pkg::*;

    localparam int IDX_W = $clog2(WORDS);

    logic [IDX_W-1:0] word_idx;
    logic             out_of_range;

    assign word_idx     = addr[IDX_W+1:2];
    assign out_of_range = (addr >> (IDX_W + 2)) != '0;
    assign misalign     = addr[1:0] != 2'b00;

    // Read the addressed word, substituting NOP when the byte address lies past the ROM.
    always_comb begin
        data = imem_image_word(32'(word_idx));
        if (out_of_range) begin
            data = IMEM_NOP;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Memory end of the fetch interface: fixed-latency ROM access with busy, valid and flush.
module imem_responder #(
    parameter int N     = 64,
    parameter int WORDS = 64,
    parameter int LAT   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         imem_req,
    input  logic [N-1:0] imem_addr,
    input  logic         flush,
    output logic [31:0]  imem_data,
    output logic         imem_valid,
    output logic         imem_busy,
    output logic         imem_misalign
);
    import imem_pkg::*;

    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    imem_state_t      state;
    imem_state_t      next_state;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     rom_addr;
    logic [31:0]      rom_data;
    logic             rom_misalign;
    logic             accept;
    logic             enter_resp;

    // A new fetch is taken only when no access is pending and no redirect is in progress.
    assign accept     = imem_req & ~flush & ((state == IDLE) | (state == RESP));
    assign enter_resp = (next_state == RESP);

    // With single-cycle latency the response is captured on the accept edge itself,
    // so the ROM must see the live PC; otherwise it reads the address latched at accept.
    if (LAT == 1) begin : g_direct_addr
        assign rom_addr = imem_addr;
    end else begin : g_latched_addr
        logic [N-1:0] addr_q;

        // Capture the PC on accept so later changes cannot disturb the in-flight access.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                addr_q <= '0;
            end else if (accept) begin
                addr_q <= imem_addr;
            end
        end

        assign rom_addr = addr_q;
    end

    imem_rom #(
        .N     (N),
        .WORDS (WORDS)
    ) u_rom (
        .addr     (rom_addr),
        .data     (rom_data),
        .misalign (rom_misalign)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: flush always abandons, WAIT ends when the counter reaches one.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (LAT == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    next_state = IDLE;
                end else if (cnt <= CNT_ONE) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (accept) begin
                    next_state = (LAT == 1) ? RESP : WAIT;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output logic: valid is masked by flush so a redirect never sees a stale instruction.
    always_comb begin
        imem_valid = (state == RESP) & ~flush;
        imem_busy  = (state == WAIT);
    end

    // Latency counter: loaded on accept, counts down while waiting, cleared by flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_LOAD;
        end else if (state == WAIT) begin
            if (flush) begin
                cnt <= '0;
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    // Response registers: loaded only on the edge entering RESP, held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_data     <= '0;
            imem_misalign <= 1'b0;
        end else if (enter_resp) begin
            imem_data     <= rom_misalign ? IMEM_NOP : rom_data;
            imem_misalign <= rom_misalign;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder across several latency and depth configurations.
module tb_imem_responder;
    import imem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int compare_count  = 0;
    int mismatch_count = 0;

    // LAT=2, WORDS=64
    logic        rst_l2, req_l2, flush_l2;
    logic [63:0] addr_l2;
    logic [31:0] data_l2;
    logic        valid_l2, busy_l2, mis_l2;
    // LAT=1, WORDS=64
    logic        rst_l1, req_l1, flush_l1;
    logic [63:0] addr_l1;
    logic [31:0] data_l1;
    logic        valid_l1, busy_l1, mis_l1;
    // LAT=3, WORDS=64
    logic        rst_l3, req_l3, flush_l3;
    logic [63:0] addr_l3;
    logic [31:0] data_l3;
    logic        valid_l3, busy_l3, mis_l3;
    // LAT=2, WORDS=4
    logic        rst_w4, req_w4, flush_w4;
    logic [63:0] addr_w4;
    logic [31:0] data_w4;
    logic        valid_w4, busy_w4, mis_w4;

    imem_responder #(.N(64), .WORDS(64), .LAT(2)) u_lat2 (
        .clk(clk), .reset(rst_l2), .imem_req(req_l2), .imem_addr(addr_l2), .flush(flush_l2),
        .imem_data(data_l2), .imem_valid(valid_l2), .imem_busy(busy_l2), .imem_misalign(mis_l2));

    imem_responder #(.N(64), .WORDS(64), .LAT(1)) u_lat1 (
        .clk(clk), .reset(rst_l1), .imem_req(req_l1), .imem_addr(addr_l1), .flush(flush_l1),
        .imem_data(data_l1), .imem_valid(valid_l1), .imem_busy(busy_l1), .imem_misalign(mis_l1));

    imem_responder #(.N(64), .WORDS(64), .LAT(3)) u_lat3 (
        .clk(clk), .reset(rst_l3), .imem_req(req_l3), .imem_addr(addr_l3), .flush(flush_l3),
        .imem_data(data_l3), .imem_valid(valid_l3), .imem_busy(busy_l3), .imem_misalign(mis_l3));

    imem_responder #(.N(64), .WORDS(4), .LAT(2)) u_w4 (
        .clk(clk), .reset(rst_w4), .imem_req(req_w4), .imem_addr(addr_w4), .flush(flush_w4),
        .imem_data(data_w4), .imem_valid(valid_w4), .imem_busy(busy_w4), .imem_misalign(mis_w4));

    // Compare one observed value against its expected value and log any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Move to just after the next rising edge so new inputs apply to the following cycle.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_l2 = 1'b1; req_l2 = 1'b0; flush_l2 = 1'b0; addr_l2 = '0;
        rst_l1 = 1'b1; req_l1 = 1'b0; flush_l1 = 1'b0; addr_l1 = '0;
        rst_l3 = 1'b1; req_l3 = 1'b0; flush_l3 = 1'b0; addr_l3 = '0;
        rst_w4 = 1'b1; req_w4 = 1'b0; flush_w4 = 1'b0; addr_w4 = '0;
        #2;
        checkOutput("rst_data",  64'(data_l2),  64'h0);
        checkOutput("rst_valid", 64'(valid_l2), 64'h0);
        checkOutput("rst_busy",  64'(busy_l2),  64'h0);
        checkOutput("rst_mis",   64'(mis_l2),   64'h0);
        applyStimulus();
        applyStimulus();
        rst_l2 = 1'b0; rst_l1 = 1'b0; rst_l3 = 1'b0; rst_w4 = 1'b0;

        // Single access at LAT=2: busy one cycle, then valid with word 1.
        applyStimulus();
        req_l2 = 1'b1; addr_l2 = 64'h4; #2;
        checkOutput("l2_c1_valid", 64'(valid_l2), 64'h0);
        checkOutput("l2_c1_busy",  64'(busy_l2),  64'h0);
        applyStimulus();
        req_l2 = 1'b0; addr_l2 = 64'h0; #2;
        checkOutput("l2_c2_busy",  64'(busy_l2),  64'h1);
        checkOutput("l2_c2_valid", 64'(valid_l2), 64'h0);
        applyStimulus();
        #2;
        checkOutput("l2_c3_valid", 64'(valid_l2), 64'h1);
        checkOutput("l2_c3_data",  64'(data_l2),  64'h8B020023);
        checkOutput("l2_c3_busy",  64'(busy_l2),  64'h0);
        checkOutput("l2_c3_mis",   64'(mis_l2),   64'h0);
        applyStimulus();
        #2;
        checkOutput("l2_c4_valid", 64'(valid_l2), 64'h0);
        checkOutput("l2_c4_busy",  64'(busy_l2),  64'h0);
        checkOutput("l2_c4_hold",  64'(data_l2),  64'h8B020023);

        // Reset during WAIT: outputs clear at once and the pending word never appears.
        applyStimulus();
        req_l2 = 1'b1; addr_l2 = 64'h0; #2;
        applyStimulus();
        req_l2 = 1'b0; rst_l2 = 1'b1; #2;
        checkOutput("rstw_data",  64'(data_l2),  64'h0);
        checkOutput("rstw_valid", 64'(valid_l2), 64'h0);
        checkOutput("rstw_busy",  64'(busy_l2),  64'h0);
        checkOutput("rstw_mis",   64'(mis_l2),   64'h0);
        applyStimulus();
        rst_l2 = 1'b0; #2;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            #2;
            checkOutput("rstw_after_valid", 64'(valid_l2), 64'h0);
            checkOutput("rstw_after_busy",  64'(busy_l2),  64'h0);
            checkOutput("rstw_after_data",  64'(data_l2),  64'h0);
        end

        // Back-to-back at LAT=1: three consecutive valid words, never busy.
        applyStimulus();
        req_l1 = 1'b1; addr_l1 = 64'h0; #2;
        checkOutput("l1_c1_valid", 64'(valid_l1), 64'h0);
        applyStimulus();
        addr_l1 = 64'h4; #2;
        checkOutput("l1_c2_valid", 64'(valid_l1), 64'h1);
        checkOutput("l1_c2_data",  64'(data_l1),  64'hF8400020);
        checkOutput("l1_c2_busy",  64'(busy_l1),  64'h0);
        applyStimulus();
        addr_l1 = 64'h8; #2;
        checkOutput("l1_c3_valid", 64'(valid_l1), 64'h1);
        checkOutput("l1_c3_data",  64'(data_l1),  64'h8B020023);
        checkOutput("l1_c3_busy",  64'(busy_l1),  64'h0);
        applyStimulus();
        req_l1 = 1'b0; addr_l1 = 64'h0; #2;
        checkOutput("l1_c4_valid", 64'(valid_l1), 64'h1);
        checkOutput("l1_c4_data",  64'(data_l1),  64'hCB050086);
        checkOutput("l1_c4_busy",  64'(busy_l1),  64'h0);
        applyStimulus();
        #2;
        checkOutput("l1_c5_valid", 64'(valid_l1), 64'h0);
        checkOutput("l1_c5_busy",  64'(busy_l1),  64'h0);

        // Flush alongside a request in IDLE blocks acceptance.
        applyStimulus();
        req_l1 = 1'b1; addr_l1 = 64'hC; flush_l1 = 1'b1; #2;
        checkOutput("l1_fr_valid", 64'(valid_l1), 64'h0);
        applyStimulus();
        req_l1 = 1'b0; flush_l1 = 1'b0; #2;
        checkOutput("l1_fr_next_valid", 64'(valid_l1), 64'h0);
        checkOutput("l1_fr_next_data",  64'(data_l1),  64'hCB050086);

        // Flush during RESP suppresses the valid pulse.
        applyStimulus();
        req_l1 = 1'b1; addr_l1 = 64'hC; #2;
        applyStimulus();
        req_l1 = 1'b0; flush_l1 = 1'b1; #2;
        checkOutput("l1_fresp_valid", 64'(valid_l1), 64'h0);
        checkOutput("l1_fresp_data",  64'(data_l1),  64'hB4000060);
        applyStimulus();
        flush_l1 = 1'b0; #2;
        checkOutput("l1_fresp_idle_valid", 64'(valid_l1), 64'h0);
        checkOutput("l1_fresp_idle_busy",  64'(busy_l1),  64'h0);

        // Flush at LAT=3 in the second WAIT cycle abandons the access.
        applyStimulus();
        req_l3 = 1'b1; addr_l3 = 64'hC; #2;
        applyStimulus();
        req_l3 = 1'b0; addr_l3 = 64'h0; #2;
        checkOutput("l3_w1_busy", 64'(busy_l3), 64'h1);
        applyStimulus();
        flush_l3 = 1'b1; #2;
        checkOutput("l3_w2_busy",  64'(busy_l3),  64'h1);
        checkOutput("l3_w2_valid", 64'(valid_l3), 64'h0);
        applyStimulus();
        flush_l3 = 1'b0; req_l3 = 1'b1; addr_l3 = 64'h0; #2;
        checkOutput("l3_idle_busy",  64'(busy_l3),  64'h0);
        checkOutput("l3_idle_valid", 64'(valid_l3), 64'h0);
        checkOutput("l3_idle_data",  64'(data_l3),  64'h0);
        applyStimulus();
        req_l3 = 1'b0; #2;
        checkOutput("l3_r_w1_busy",  64'(busy_l3),  64'h1);
        checkOutput("l3_r_w1_valid", 64'(valid_l3), 64'h0);
        applyStimulus();
        #2;
        checkOutput("l3_r_w2_busy",  64'(busy_l3),  64'h1);
        checkOutput("l3_r_w2_valid", 64'(valid_l3), 64'h0);
        applyStimulus();
        #2;
        checkOutput("l3_r_valid", 64'(valid_l3), 64'h1);
        checkOutput("l3_r_data",  64'(data_l3),  64'hF8400020);
        checkOutput("l3_r_busy",  64'(busy_l3),  64'h0);
        applyStimulus();
        #2;
        checkOutput("l3_r_done_valid", 64'(valid_l3), 64'h0);

        // WORDS=4: address just past the ROM reads as NOP, not misaligned.
        applyStimulus();
        req_w4 = 1'b1; addr_w4 = 64'h10; #2;
        applyStimulus();
        req_w4 = 1'b0; #2;
        applyStimulus();
        #2;
        checkOutput("w4_oob_valid", 64'(valid_w4), 64'h1);
        checkOutput("w4_oob_data",  64'(data_w4),  64'(IMEM_NOP));
        checkOutput("w4_oob_mis",   64'(mis_w4),   64'h0);

        // Misaligned address reads as NOP with the misalign flag set.
        applyStimulus();
        req_w4 = 1'b1; addr_w4 = 64'h6; #2;
        applyStimulus();
        req_w4 = 1'b0; #2;
        applyStimulus();
        #2;
        checkOutput("w4_mis_valid", 64'(valid_w4), 64'h1);
        checkOutput("w4_mis_data",  64'(data_w4),  64'(IMEM_NOP));
        checkOutput("w4_mis_flag",  64'(mis_w4),   64'h1);

        // Request held through WAIT with a new address is ignored.
        applyStimulus();
        req_w4 = 1'b1; addr_w4 = 64'h8; #2;
        applyStimulus();
        addr_w4 = 64'h0; #2;
        checkOutput("w4_hold_busy", 64'(busy_w4), 64'h1);
        applyStimulus();
        req_w4 = 1'b0; #2;
        checkOutput("w4_hold_valid", 64'(valid_w4), 64'h1);
        checkOutput("w4_hold_data",  64'(data_w4),  64'hCB050086);
        checkOutput("w4_hold_mis",   64'(mis_w4),   64'h0);
        applyStimulus();
        #2;
        checkOutput("w4_hold_done_valid", 64'(valid_w4), 64'h0);
        checkOutput("w4_hold_done_busy",  64'(busy_w4),  64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
